pipeline_hazard_unit: RTL

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

---
 rtl/pipeline_hazard_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: scoreboard interlock, branch flush and data-memory freeze.
// Define FORWARDING_EN to enable EX/MEM/WB bypass selects and limit stalls to load-use.
//
// state  | meaning
// RUN    | pipeline advancing normally
// STALL  | DEC waits on an in-flight producer; bubble into EX
// FLUSH  | taken branch/JAL in EX; squash IF/DEC and DEC/EX
// FREEZE | data memory busy; everything holds, scoreboard included
module pipeline_hazard_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  DEC_op,
    input  logic [3:0]  DEC_rs1,
    input  logic [3:0]  DEC_rs2,
    input  logic [3:0]  DEC_rd,
    input  logic        DEC_valid,
    input  logic        ex_br_taken,
    input  logic        mem_stall_req,
    output logic        pc_en,
    output logic        if_dec_en,
    output logic        dec_bubble,
    output logic        flush_if_dec,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  hz_state,
    output logic [15:0] bubble_cnt
);

    localparam logic [3:0] OP_ALUR   = 4'd0;
    localparam logic [3:0] OP_ALUI   = 4'd1;
    localparam logic [3:0] OP_LWOP   = 4'd2;
    localparam logic [3:0] OP_SWOP   = 4'd3;
    localparam logic [3:0] OP_CMPR   = 4'd4;
    localparam logic [3:0] OP_CMPI   = 4'd5;
    localparam logic [3:0] OP_BRANCH = 4'd6;
    localparam logic [3:0] OP_JAL    = 4'd7;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        FLUSH  = 2'b10,
        FREEZE = 2'b11
    } hz_state_t;

    hz_state_t state_q, state_d;

    logic writes_rd, reads_rs1, reads_rs2;

    always_comb begin
        writes_rd = 1'b0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        case (DEC_op)
            OP_ALUR, OP_CMPR: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            OP_ALUI, OP_LWOP, OP_CMPI, OP_JAL: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
            end
            OP_SWOP, OP_BRANCH: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Scoreboard index 0 = EX, 1 = MEM, 2 = WB.
    logic [2:0] sb_valid;
    logic [2:0] sb_load;
    logic [3:0] sb_rd [3];
    logic       sb_load_unused;

    assign sb_load_unused = sb_load[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            sb_load  <= '0;
            for (int i = 0; i < 3; i++) sb_rd[i] <= '0;
        end else if (!mem_stall_req) begin
            sb_valid <= {sb_valid[1:0], DEC_valid & writes_rd & ~dec_bubble};
            sb_load  <= {sb_load[1:0], DEC_op == OP_LWOP};
            sb_rd[2] <= sb_rd[1];
            sb_rd[1] <= sb_rd[0];
            sb_rd[0] <= DEC_rd;
        end
    end

    logic [2:0] dep_a, dep_b;

    always_comb begin
        dep_a = '0;
        dep_b = '0;
        for (int i = 0; i < 3; i++) begin
            dep_a[i] = sb_valid[i] & DEC_valid & reads_rs1 & (sb_rd[i] == DEC_rs1);
            dep_b[i] = sb_valid[i] & DEC_valid & reads_rs2 & (sb_rd[i] == DEC_rs2);
        end
    end

    logic data_hazard;

`ifdef FORWARDING_EN
    // With bypassing only a load still in EX cannot supply its result in time.
    assign data_hazard = (dep_a[0] | dep_b[0]) & sb_load[0];

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (dep_a[2]) fwd_a = 2'b11;
        if (dep_a[1]) fwd_a = 2'b10;
        if (dep_a[0]) fwd_a = 2'b01;
        if (dep_b[2]) fwd_b = 2'b11;
        if (dep_b[1]) fwd_b = 2'b10;
        if (dep_b[0]) fwd_b = 2'b01;
    end
`else
    assign data_hazard = |(dep_a | dep_b);
    assign fwd_a       = 2'b00;
    assign fwd_b       = 2'b00;
`endif

    always_comb begin
        state_d      = RUN;
        pc_en        = 1'b1;
        if_dec_en    = 1'b1;
        dec_bubble   = 1'b0;
        flush_if_dec = 1'b0;
        if (!rst_n)             state_d = RUN;
        else if (mem_stall_req) state_d = FREEZE;
        else if (ex_br_taken)   state_d = FLUSH;
        else if (data_hazard)   state_d = STALL;
        case (state_d)
            FREEZE: begin
                pc_en     = 1'b0;
                if_dec_en = 1'b0;
            end
            FLUSH: begin
                dec_bubble   = 1'b1;
                flush_if_dec = 1'b1;
            end
            STALL: begin
                pc_en      = 1'b0;
                if_dec_en  = 1'b0;
                dec_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    assign hz_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (dec_bubble && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
    end

endmodule
